// File: rtl/neuron_mac_scheduler_pkg.sv
// Shared types and widths for the neuron MAC scheduler and its multiplier.
package neuron_mac_scheduler_pkg;
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/neuron_mac_scheduler_mult.sv
// Existing unsigned 4x4 combinational multiplier shared by every MAC step.
module four_bit_multiplier
    import neuron_mac_scheduler_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);
    assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/neuron_mac_scheduler.sv
// Sequential dot-product controller time-sharing one 4x4 multiplier over N pairs.
// Optional accumulator saturation when NEURON_ACC_SAT_EN is defined (default: wrap).
//
// state | meaning
// IDLE  | waiting for start; result held
// LOAD  | pair 0 moved into multiplier input registers
// RUN   | one product added per cycle, then one settle cycle before DONE
// DONE  | result published, done pulse
module neuron_mac_scheduler
    import neuron_mac_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [4*N-1:0]    x_flat,
    input  logic [4*N-1:0]    w_flat,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);
    localparam int IDX_W = $clog2(N);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_inc;
    logic                 settle;
    logic [4*N-1:0]       x_q;
    logic [4*N-1:0]       w_q;
    logic [OP_W-1:0]      mul_a;
    logic [OP_W-1:0]      mul_b;
    logic [PROD_W-1:0]    prod;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_nxt;

    four_bit_multiplier u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    assign idx_inc = idx + 1'b1;

`ifdef NEURON_ACC_SAT_EN
    logic [ACC_W:0] acc_sum;
    always_comb begin
        acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
        acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_nxt = acc + ACC_W'(prod);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            idx    <= '0;
            settle <= 1'b0;
            x_q    <= '0;
            w_q    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q    <= x_flat;
                        w_q    <= w_flat;
                        acc    <= '0;
                        idx    <= '0;
                        settle <= 1'b0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        mul_a <= x_q[OP_W-1:0];
                        mul_b <= w_q[OP_W-1:0];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else if (settle) begin
                        result <= acc;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        acc <= acc_nxt;
                        // Index parks at N-1; the settle cycle follows the final add.
                        if (idx == IDX_W'(N-1)) begin
                            settle <= 1'b1;
                        end else begin
                            idx   <= idx_inc;
                            mul_a <= x_q[OP_W*int'(idx_inc) +: OP_W];
                            mul_b <= w_q[OP_W*int'(idx_inc) +: OP_W];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// Directed self-checking bench: default ACC_W=10 instance plus an ACC_W=9 instance on shared stimulus.
module tb_neuron_mac_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] x_flat;
    logic [15:0] w_flat;
    logic        busy, done, busy9, done9;
    logic [9:0]  result;
    logic [8:0]  result9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    neuron_mac_scheduler #(.N(4), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_flat(x_flat), .w_flat(w_flat),
        .busy(busy), .done(done), .result(result)
    );

    neuron_mac_scheduler #(.N(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_flat(x_flat), .w_flat(w_flat),
        .busy(busy9), .done(done9), .result(result9)
    );

`ifdef NEURON_ACC_SAT_EN
    localparam int EXP_SAT9 = 511;
`else
    localparam int EXP_SAT9 = 388;
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    // Start a run and follow it to the done cycle; returns with done sampled high.
    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                          input int exp_res, input int exp9, input bit mid_start, input int hold);
        int cnt;
        int bad_hold;
        x_flat = xv;
        w_flat = wv;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        cnt      = 0;
        bad_hold = 0;
        while (busy && cnt < 50) begin
            cnt++;
            if (hold >= 0 && int'(result) != hold) bad_hold++;
            if (mid_start && cnt == 2) begin
                start  = 1'b1;
                x_flat = '1;
                w_flat = '1;
            end
            tick();
            start = 1'b0;
        end
        check({tag, "_busy_cycles"}, cnt, 6);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_result"}, int'(result), exp_res);
        if (exp9 >= 0) check({tag, "_result9"}, int'(result9), exp9);
        if (hold >= 0) check({tag, "_hold"}, bad_hold, 0);
    endtask

    initial begin
        int bad_done;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        x_flat = '0;
        w_flat = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        check("reset_result9", int'(result9), 0);

        run_op("basic", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 70, -1, 1'b0, -1);
        tick();
        check("basic_done_pulse_len", int'(done), 0);

        run_op("max", pack4(15, 15, 15, 15), pack4(15, 15, 15, 15), 900, EXP_SAT9, 1'b0, -1);
        tick();
        run_op("zero", '0, '0, 0, 0, 1'b0, -1);
        tick();

        // Start pulsed mid-run with different operands must not disturb the run.
        run_op("midstart", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 70, -1, 1'b1, 0);
        tick();
        check("midstart_no_requeue", int'(busy), 0);

        // Abort in the third RUN cycle.
        x_flat = pack4(15, 15, 15, 15);
        w_flat = pack4(1, 1, 1, 1);
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 70);
        bad_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) bad_done++;
            tick();
        end
        check("abort_no_done", bad_done, 0);

        // Reset in the middle of RUN.
        x_flat = pack4(1, 2, 3, 4);
        w_flat = pack4(5, 6, 7, 8);
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        tick();
        check("rst_idle", int'(busy), 0);
        run_op("after_rst", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 70, -1, 1'b0, 0);

        // Start during the done cycle is ignored; start in the next cycle is accepted.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_ignored", int'(busy), 0);
        check("done_start_result", int'(result), 70);
        run_op("b2b", pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 24, 24, 1'b0, 70);
        tick();
        check("b2b_final_done_low", int'(done), 0);
        check("b2b_result_held", int'(result), 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
